// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state encoding,
// default operand width and the bit-counter width helper.
package serial_add_pkg;

    // Default operand/sum width in bits (legal range 2..32).
    localparam int unsigned WIDTH_DEFAULT = 4;

    // FSM state type and encodings (plain constants for legacy compatibility).
    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t DONE = 2'd2;

    // Bit-counter width: enough to count 0..w-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_add_ctrl_fa_cell.sv
// Combinational 1-bit full adder cell; the only arithmetic in the serial adder.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    // Sum and carry of three input bits.
    always_comb begin
        s  = a ^ b ^ ci;
        co = (a & b) | (ci & (a ^ b));
    end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder cell is sequenced over WIDTH
// cycles with a carry flop between bits; start/busy/done handshake.
// Optional feature macro SERIAL_ADD_SUB_EN adds a 'sub' input (a - b).
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    // Result bits already produced; the bit of the current edge completes it.
    logic [WIDTH-2:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic             fa_s, fa_co;
    logic [WIDTH-1:0] res_next;
    logic [WIDTH-1:0] b_load;
    logic             c_load;
    logic             accept;

    fa_cell u_fa (
        .a  (a_q[0]),
        .b  (b_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    // Operand conditioning at latch time: subtraction is a + ~b + 1.
    always_comb begin
`ifdef SERIAL_ADD_SUB_EN
        b_load = sub ? ~b : b;
        c_load = sub ? 1'b1 : cin;
`else
        b_load = b;
        c_load = cin;
`endif
    end

    // Start is honoured only when not mid-operation (IDLE or DONE).
    always_comb begin
        accept   = start && ((state_q == IDLE) || (state_q == DONE));
        res_next = {fa_s, res_q};
    end

    // Next-state logic: load on accept, one bit per edge in RUN.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (accept) begin
                    a_d     = a;
                    b_d     = b_load;
                    carry_d = c_load;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                res_d   = res_next[WIDTH-1:1];
                carry_d = fa_co;
                a_d     = {1'b0, a_q[WIDTH-1:1]};
                b_d     = {1'b0, b_q[WIDTH-1:1]};
                if (cnt_q == LAST) begin
                    sum_d   = res_next;
                    cout_d  = fa_co;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers, all cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    // Status decoded from state; result outputs held in their own flops.
    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == DONE);
        sum  = sum_q;
        cout = cout_q;
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl (WIDTH=4).
module tb_serial_add_ctrl;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         busy, done, cout;
    logic [W-1:0] sum;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SERIAL_ADD_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W:0] res;
        int         done_cyc;
    } exp_t;

    exp_t       exp_q[$];
    int         cyc = 0;
    int         acc_t = -1000;
    int         checks = 0;
    int         failures = 0;
    logic [W:0] last_res = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain unsigned arithmetic, truncated to W+1 bits.
    function automatic logic [W:0] ref_result(input int aa, input int bb, input int c,
                                              input int sb);
        int r;
        if (sb != 0) r = aa + (1 << W) - bb;
        else         r = aa + bb + c;
        return r[W:0];
    endfunction

    // Model of the operation window: RUN spans W cycles after acceptance.
    function automatic bit model_busy(input int k);
        return (k >= acc_t) && (k < acc_t + W);
    endfunction

    // One cycle of stimulus; reports whether the model expects acceptance.
    task automatic step(input logic s, input logic [W-1:0] aa, input logic [W-1:0] bb,
                        input logic c, input logic sb, output bit acc);
        @(posedge clk);
        #2;
        start = s;
        a     = aa;
        b     = bb;
        cin   = c;
        sub   = sb;
        acc   = s && !model_busy(cyc);
        if (acc) begin
            acc_t = cyc + 1;
            exp_q.push_back('{res: ref_result(int'(aa), int'(bb), int'(c), int'(sb)),
                              done_cyc: cyc + 1 + W});
        end
    endtask

    task automatic idle(input int n);
        bit acc;
        repeat (n) step(1'b0, '0, '0, 1'b0, 1'b0, acc);
    endtask

    task automatic op(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic c,
                      input logic sb);
        bit acc;
        int tries = 0;
        do begin
            step(1'b1, aa, bb, c, sb, acc);
            tries++;
        end while (!acc && tries < 20);
        check("accept_bound", int'(acc), 1);
    endtask

    // Monitor: busy vs model, done vs scoreboard, results held otherwise.
    always @(negedge clk) begin
        if (rst_n) begin
            check("busy", int'(busy), int'(model_busy(cyc)));
            if (exp_q.size() > 0 && cyc > exp_q[0].done_cyc) begin
                check("done_missing", 0, 1);
                void'(exp_q.pop_front());
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("done_spurious", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("done_cycle", cyc, e.done_cyc);
                    check("sum", int'(sum), int'(e.res[W-1:0]));
                    check("cout", int'(cout), int'(e.res[W]));
                    last_res = e.res;
                end
            end else begin
                check("sum_held", int'(sum), int'(last_res[W-1:0]));
                check("cout_held", int'(cout), int'(last_res[W]));
            end
        end
    end

    initial begin
        bit acc;
        int n;

        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_sum", int'(sum), 0);
        check("rst_cout", int'(cout), 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // Directed single operations.
        op(4'b0101, 4'b0011, 1'b0, 1'b0);
        idle(7);
        op(4'b1111, 4'b0001, 1'b0, 1'b0);
        idle(2);
        op(4'b0000, 4'b0000, 1'b1, 1'b0);
        idle(7);

        // Start during RUN is ignored.
        op(4'h9, 4'h6, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b0, acc);
        step(1'b1, 4'hf, 4'hf, 1'b1, 1'b0, acc);
        check("ignored_start", int'(acc), 0);
        idle(6);

        // Back-to-back with start held and operands changing every cycle.
        repeat (16) step(1'b1, W'($urandom), W'($urandom), 1'($urandom), 1'b0, acc);
        idle(7);

        // Asynchronous reset mid-RUN.
        op(4'h7, 4'h8, 1'b1, 1'b0);
        idle(2);
        rst_n = 1'b0;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_sum", int'(sum), 0);
        check("abort_cout", int'(cout), 0);
        exp_q.delete();
        acc_t    = -1000;
        last_res = '0;
        start    = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        op(4'hc, 4'h5, 1'b0, 1'b0);
        idle(7);

        // Exhaustive add.
        for (int i = 0; i < 512; i++) op(W'(i), W'(i >> 4), 1'(i >> 8), 1'b0);
        idle(7);

        // Randomized stimulus with sparse starts.
        repeat (300) begin
            step(1'($urandom_range(0, 2) == 0), W'($urandom), W'($urandom), 1'($urandom),
`ifdef SERIAL_ADD_SUB_EN
                 1'($urandom),
`else
                 1'b0,
`endif
                 acc);
        end

`ifdef SERIAL_ADD_SUB_EN
        idle(7);
        op(4'd3, 4'd5, 1'b1, 1'b1);
        idle(7);
        check("sub_3_5", int'({cout, sum}), int'(5'b0_1110));
`endif

        // Drain outstanding results within a bounded window.
        n = 0;
        while (exp_q.size() > 0 && n < 40) begin
            idle(1);
            n++;
        end
        check("drain", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
